// File: rtl/fetch_group_unit.sv
// Eight-wide fetch stage: issues group-aligned memory requests under a 2-credit
// window, buffers up to two returned groups and presents the head group per lane.
module fetch_group_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         CLR_N,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [255:0] imem_rdata,
  input  logic         StallD,
  input  logic         Redirect,
  input  logic [31:0]  RedirectPC,
  output logic [31:0]  InstrF0,
  output logic [31:0]  InstrF1,
  output logic [31:0]  InstrF2,
  output logic [31:0]  InstrF3,
  output logic [31:0]  InstrF4,
  output logic [31:0]  InstrF5,
  output logic [31:0]  InstrF6,
  output logic [31:0]  InstrF7,
  output logic [31:0]  PCF0,
  output logic [31:0]  PCF1,
  output logic [31:0]  PCF2,
  output logic [31:0]  PCF3,
  output logic [31:0]  PCF4,
  output logic [31:0]  PCF5,
  output logic [31:0]  PCF6,
  output logic [31:0]  PCF7,
  output logic [7:0]   ValidF
);

  localparam logic [31:0] RESET_BASE = {RESET_PC[31:5], 5'b0};
  localparam logic [7:0]  RESET_MASK = 8'hFF << RESET_PC[4:2];

  logic [31:0]  fetch_pc_reg, fetch_pc_next;
  logic [7:0]   first_mask_reg, first_mask_next;
  logic [1:0]   outstanding_reg, outstanding_next;
  logic [1:0]   drop_cnt_reg, drop_cnt_next;

  // In-order tag queue: base and lane mask of every outstanding request
  logic [31:0]  tag_base_reg [2];
  logic [7:0]   tag_mask_reg [2];
  logic         tag_wr_ptr_reg, tag_wr_ptr_next;
  logic         tag_rd_ptr_reg, tag_rd_ptr_next;

  logic [255:0] fifo_data_reg [2];
  logic [31:0]  fifo_base_reg [2];
  logic [7:0]   fifo_mask_reg [2];
  logic         fifo_wr_ptr_reg, fifo_wr_ptr_next;
  logic         fifo_rd_ptr_reg, fifo_rd_ptr_next;
  logic [1:0]   fifo_count_reg, fifo_count_next;

  logic         pop;
  logic         grant;
  logic         rsp;
  logic         push;
  logic [2:0]   credits_used;

  logic         unused_redirect_bits;
  assign unused_redirect_bits = ^RedirectPC[1:0];

  // Credits count both in-flight requests and buffered groups, so a response
  // always finds a free FIFO slot.
  always_comb begin
    pop          = (fifo_count_reg != 2'd0) & ~StallD & ~Redirect;
    credits_used = {1'b0, outstanding_reg} + {1'b0, fifo_count_reg} - {2'b00, pop};
    imem_req     = CLR_N & ~Redirect & (credits_used < 3'd2);
    grant        = imem_req & imem_gnt;
    rsp          = imem_rvalid & (outstanding_reg != 2'd0);
    push         = rsp & (drop_cnt_reg == 2'd0) & ~Redirect;
  end

  assign imem_addr = fetch_pc_reg;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    first_mask_next  = first_mask_reg;
    outstanding_next = outstanding_reg + {1'b0, grant} - {1'b0, rsp};
    drop_cnt_next    = drop_cnt_reg;
    tag_wr_ptr_next  = tag_wr_ptr_reg ^ grant;
    tag_rd_ptr_next  = tag_rd_ptr_reg ^ rsp;
    fifo_wr_ptr_next = fifo_wr_ptr_reg ^ push;
    fifo_rd_ptr_next = fifo_rd_ptr_reg ^ pop;
    fifo_count_next  = fifo_count_reg + {1'b0, push} - {1'b0, pop};

    if (grant) begin
      fetch_pc_next   = fetch_pc_reg + 32'd32;
      first_mask_next = 8'hFF;
    end

    if (rsp && (drop_cnt_reg != 2'd0)) begin
      drop_cnt_next = drop_cnt_reg - 2'd1;
    end

    // Everything still in flight after this cycle belongs to the old path
    if (Redirect) begin
      fetch_pc_next    = {RedirectPC[31:5], 5'b0};
      first_mask_next  = 8'hFF << RedirectPC[4:2];
      drop_cnt_next    = outstanding_next;
      fifo_count_next  = 2'd0;
      fifo_wr_ptr_next = 1'b0;
      fifo_rd_ptr_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge CLR_N) begin
    if (!CLR_N) begin
      fetch_pc_reg    <= RESET_BASE;
      first_mask_reg  <= RESET_MASK;
      outstanding_reg <= 2'd0;
      drop_cnt_reg    <= 2'd0;
      tag_wr_ptr_reg  <= 1'b0;
      tag_rd_ptr_reg  <= 1'b0;
      fifo_wr_ptr_reg <= 1'b0;
      fifo_rd_ptr_reg <= 1'b0;
      fifo_count_reg  <= 2'd0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      first_mask_reg  <= first_mask_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
      tag_wr_ptr_reg  <= tag_wr_ptr_next;
      tag_rd_ptr_reg  <= tag_rd_ptr_next;
      fifo_wr_ptr_reg <= fifo_wr_ptr_next;
      fifo_rd_ptr_reg <= fifo_rd_ptr_next;
      fifo_count_reg  <= fifo_count_next;
    end
  end

  // Payload storage carries no reset; the count alone qualifies it
  always_ff @(posedge clk) begin
    if (grant) begin
      tag_base_reg[tag_wr_ptr_reg] <= fetch_pc_reg;
      tag_mask_reg[tag_wr_ptr_reg] <= first_mask_reg;
    end
    if (push) begin
      fifo_data_reg[fifo_wr_ptr_reg] <= imem_rdata;
      fifo_base_reg[fifo_wr_ptr_reg] <= tag_base_reg[tag_rd_ptr_reg];
      fifo_mask_reg[fifo_wr_ptr_reg] <= tag_mask_reg[tag_rd_ptr_reg];
    end
  end

  logic         head_valid;
  logic [255:0] head_data;
  logic [31:0]  head_base;
  logic [7:0]   head_mask;
  logic [31:0]  instr_lane [8];
  logic [31:0]  pc_lane [8];

  assign head_valid = (fifo_count_reg != 2'd0);
  assign head_data  = fifo_data_reg[fifo_rd_ptr_reg];
  assign head_base  = fifo_base_reg[fifo_rd_ptr_reg];
  assign head_mask  = fifo_mask_reg[fifo_rd_ptr_reg];
  assign ValidF     = head_valid ? head_mask : 8'h00;

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    // Base is 32-byte aligned, so the lane offset just fills bits [4:2]
    assign instr_lane[gi] = (head_valid && head_mask[gi]) ? head_data[32*gi +: 32] : 32'h0;
    assign pc_lane[gi]    = head_valid ? {head_base[31:5], 3'(gi), 2'b00} : 32'h0;
  end

  assign InstrF0 = instr_lane[0];
  assign InstrF1 = instr_lane[1];
  assign InstrF2 = instr_lane[2];
  assign InstrF3 = instr_lane[3];
  assign InstrF4 = instr_lane[4];
  assign InstrF5 = instr_lane[5];
  assign InstrF6 = instr_lane[6];
  assign InstrF7 = instr_lane[7];
  assign PCF0    = pc_lane[0];
  assign PCF1    = pc_lane[1];
  assign PCF2    = pc_lane[2];
  assign PCF3    = pc_lane[3];
  assign PCF4    = pc_lane[4];
  assign PCF5    = pc_lane[5];
  assign PCF6    = pc_lane[6];
  assign PCF7    = pc_lane[7];

endmodule

// File: tb/tb_fetch_group_unit.sv
// Bench for fetch_group_unit: in-order memory model with random latency, an
// address-sequence reference model feeding a scoreboard, and a group monitor.
module tb_fetch_group_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_010C;
  localparam logic [31:0] RESET_BASE  = {TB_RESET_PC[31:5], 5'b0};
  localparam logic [7:0]  RESET_MASK  = 8'hFF << TB_RESET_PC[4:2];

  logic         clk = 1'b0;
  logic         CLR_N;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [255:0] imem_rdata;
  logic         StallD;
  logic         Redirect;
  logic [31:0]  RedirectPC;
  logic [31:0]  InstrF0, InstrF1, InstrF2, InstrF3, InstrF4, InstrF5, InstrF6, InstrF7;
  logic [31:0]  PCF0, PCF1, PCF2, PCF3, PCF4, PCF5, PCF6, PCF7;
  logic [7:0]   ValidF;

  fetch_group_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .clk(clk), .CLR_N(CLR_N),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .StallD(StallD), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .InstrF0(InstrF0), .InstrF1(InstrF1), .InstrF2(InstrF2), .InstrF3(InstrF3),
    .InstrF4(InstrF4), .InstrF5(InstrF5), .InstrF6(InstrF6), .InstrF7(InstrF7),
    .PCF0(PCF0), .PCF1(PCF1), .PCF2(PCF2), .PCF3(PCF3),
    .PCF4(PCF4), .PCF5(PCF5), .PCF6(PCF6), .PCF7(PCF7),
    .ValidF(ValidF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [7:0]  mask;
  } grp_t;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  grp_t        sb[$];
  pend_t       pend[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_groups = 0;
  int unsigned cyc = 0;
  logic [31:0] seed;
  logic [31:0] exp_addr;
  logic [7:0]  exp_mask;

  logic        k_rst_n, k_stall, k_redir;
  logic [31:0] k_rpc;
  int          k_gnt_pct, k_lat_min, k_lat_max;

  logic [31:0] instr_w [8];
  logic [31:0] pc_w [8];
  assign instr_w[0] = InstrF0; assign instr_w[1] = InstrF1;
  assign instr_w[2] = InstrF2; assign instr_w[3] = InstrF3;
  assign instr_w[4] = InstrF4; assign instr_w[5] = InstrF5;
  assign instr_w[6] = InstrF6; assign instr_w[7] = InstrF7;
  assign pc_w[0] = PCF0; assign pc_w[1] = PCF1; assign pc_w[2] = PCF2; assign pc_w[3] = PCF3;
  assign pc_w[4] = PCF4; assign pc_w[5] = PCF5; assign pc_w[6] = PCF6; assign pc_w[7] = PCF7;

  // Instruction memory content is a fixed function of the byte address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ seed;
  endfunction

  function automatic logic [255:0] mem_group(input logic [31:0] a);
    logic [255:0] g;
    for (int i = 0; i < 8; i++) g[32*i +: 32] = mem_word(a + 32'(4 * i));
    return g;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock cycle: drive knobs and memory response, then account the handshake
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    CLR_N      = k_rst_n;
    StallD     = k_stall;
    Redirect   = k_redir;
    RedirectPC = k_rpc;
    imem_gnt   = ($urandom_range(99) < k_gnt_pct);
    imem_rvalid = 1'b0;
    for (int i = 0; i < 8; i++) imem_rdata[32*i +: 32] = $urandom;
    if (k_rst_n && pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_group(pend[0].addr);
      void'(pend.pop_front());
    end
    @(negedge clk);
    if (!CLR_N) begin
      chk("reset_req", imem_req, 0);
      chk("reset_validf", ValidF, 0);
      sb.delete();
      pend.delete();
      exp_addr = RESET_BASE;
      exp_mask = RESET_MASK;
    end else begin
      if (Redirect) chk("redirect_req", imem_req, 0);
      if (imem_req && imem_gnt) begin
        chk("imem_addr", imem_addr, exp_addr);
        sb.push_back('{base: exp_addr, mask: exp_mask});
        pend.push_back('{addr: imem_addr, due: cyc + $urandom_range(k_lat_max, k_lat_min)});
        exp_addr = exp_addr + 32'd32;
        exp_mask = 8'hFF;
      end
      if (Redirect) begin
        sb.delete();
        exp_addr = {RedirectPC[31:5], 5'b0};
        exp_mask = 8'hFF << RedirectPC[4:2];
      end
    end
  endtask

  // Monitor: every consumed group must be the oldest expected one; stalled output must hold
  logic        hold_prev = 1'b0;
  logic [7:0]  snap_valid;
  logic [31:0] snap_instr [8];
  logic [31:0] snap_pc [8];
  grp_t        mon_e;

  always @(negedge clk) begin
    if (!CLR_N) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_validf", ValidF, snap_valid);
        for (int i = 0; i < 8; i++) begin
          chk($sformatf("hold_instrf%0d", i), instr_w[i], snap_instr[i]);
          chk($sformatf("hold_pcf%0d", i), pc_w[i], snap_pc[i]);
        end
      end
      if (ValidF != 8'h00 && !StallD && !Redirect) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_group: got base %0h, required no group (cycle %0d)", PCF0, cyc);
        end else begin
          mon_e = sb.pop_front();
          n_groups++;
          chk("grp_validf", ValidF, mon_e.mask);
          for (int i = 0; i < 8; i++) begin
            chk($sformatf("grp_pcf%0d", i), pc_w[i], mon_e.base + 32'(4 * i));
            chk($sformatf("grp_instrf%0d", i), instr_w[i],
                mon_e.mask[i] ? mem_word(mon_e.base + 32'(4 * i)) : 32'h0);
          end
        end
      end
      hold_prev  = (ValidF != 8'h00) && StallD && !Redirect;
      snap_valid = ValidF;
      for (int i = 0; i < 8; i++) begin
        snap_instr[i] = instr_w[i];
        snap_pc[i]    = pc_w[i];
      end
    end
  end

  initial begin
    int w;
    CLR_N = 1'b0; StallD = 1'b0; Redirect = 1'b0; RedirectPC = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    seed = $urandom;
    exp_addr = RESET_BASE; exp_mask = RESET_MASK;
    k_rst_n = 1'b0; k_stall = 1'b0; k_redir = 1'b0; k_rpc = '0;
    k_gnt_pct = 100; k_lat_min = 1; k_lat_max = 1;

    repeat (3) step();
    chk("reset_instrf0", InstrF0, 0);
    chk("reset_pcf0", PCF0, 0);

    // Release with L=1: consecutive requests, first (partial) group in cycle 2
    k_rst_n = 1'b1;
    step();
    chk("c0_addr", imem_addr, 32'h100);
    chk("c0_req", imem_req, 1);
    chk("c0_validf", ValidF, 0);
    step();
    chk("c1_addr", imem_addr, 32'h120);
    chk("c1_req", imem_req, 1);
    step();
    chk("c2_addr", imem_addr, 32'h140);
    chk("c2_validf", ValidF, 8'hF8);
    chk("c2_instrf0", InstrF0, 0);
    chk("c2_pcf3", PCF3, 32'h10C);
    chk("c2_instrf3", InstrF3, mem_word(32'h10C));
    chk("c2_pcf7", PCF7, 32'h11C);
    step();
    chk("c3_validf", ValidF, 8'hFF);
    chk("c3_pcf0", PCF0, 32'h120);
    chk("c3_req", imem_req, 1);
    repeat (4) step();

    // Decode stall until the buffer is full
    k_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i >= 3) begin
        chk("stall_req", imem_req, 0);
        chk("stall_validf", ValidF, 8'hFF);
      end
    end
    k_stall = 1'b0;
    repeat (6) step();

    // Redirect together with stall on a full buffer
    k_stall = 1'b1;
    repeat (3) step();
    k_redir = 1'b1; k_rpc = 32'h100;
    step();
    k_redir = 1'b0; k_stall = 1'b0;
    step();
    chk("flush_validf", ValidF, 0);
    chk("flush_addr0", imem_addr, 32'h100);
    chk("flush_req", imem_req, 1);
    step();
    chk("flush_addr1", imem_addr, 32'h120);
    step();
    chk("flush_addr2", imem_addr, 32'h140);

    // L=3 with the credit window full, then redirect to a mid-group target
    k_lat_min = 3; k_lat_max = 3;
    repeat (8) step();
    k_redir = 1'b1; k_rpc = 32'h2008;
    step();
    k_redir = 1'b0;
    step();
    chk("redir_validf", ValidF, 0);
    chk("redir_addr", imem_addr, 32'h2000);
    w = 0;
    while (ValidF == 8'h00 && w < 20) begin
      step();
      w++;
    end
    chk("redir_group_seen", ValidF != 8'h00, 1);
    chk("redir_validf_first", ValidF, 8'hFC);
    chk("redir_pcf0", PCF0, 32'h2000);
    chk("redir_instrf1", InstrF1, 0);

    // Address wrap at the top of memory
    k_lat_min = 1; k_lat_max = 1; k_gnt_pct = 0;
    repeat (8) step();
    k_gnt_pct = 100; k_redir = 1'b1; k_rpc = 32'hFFFF_FFE4;
    step();
    k_redir = 1'b0;
    step();
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFE0);
    chk("wrap_req", imem_req, 1);
    step();
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
    step();
    chk("wrap_validf", ValidF, 8'hFE);
    chk("wrap_pcf7", PCF7, 32'hFFFF_FFFC);

    // Reset asserted mid-transfer clears outputs within the same cycle
    repeat (3) step();
    k_rst_n = 1'b0;
    step();
    chk("async_validf", ValidF, 0);
    chk("async_req", imem_req, 0);
    k_rst_n = 1'b1;
    step();
    chk("post_reset_addr", imem_addr, 32'h100);

    // Randomized traffic
    k_gnt_pct = 70; k_lat_min = 1; k_lat_max = 4;
    for (int n = 0; n < 1500; n++) begin
      k_stall = ($urandom_range(99) < 30);
      k_redir = ($urandom_range(99) < 4);
      k_rpc   = $urandom;
      if ($urandom_range(7) == 0) k_rpc = 32'hFFFF_FFC0 | {26'h0, k_rpc[5:0]};
      k_rst_n = ($urandom_range(199) != 0);
      step();
    end

    // Drain: no new grants, every expected group must have appeared
    k_rst_n = 1'b1; k_stall = 1'b0; k_redir = 1'b0; k_gnt_pct = 0;
    repeat (20) step();
    chk("drain_scoreboard_empty", sb.size(), 0);
    chk("drain_memory_idle", pend.size(), 0);
    chk("groups_consumed", n_groups >= 100, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
